geofence_ap_sorter: RTL and testbench
=====================================

// Module: geofence_ap_sorter
// PURPOSE
// - Capture stage behind the geofence point stream: takes one object point plus N_AP antenna points (AP), one per valid cycle.
// - Reorders AP1..AP(N_AP-1) by angle around pivot AP0 using cross-product bubble sort.
// - Replays the frame as object, AP0, then the sorted APs, to feed the inside-test stage.
// - Single-frame buffer; no new input accepted while sorting or emitting.
// PARAMETERS
// - W     10  coordinate width (unsigned)
// - N_AP  6   APs per frame; compare count C = (N_AP-1)*(N_AP-2)/2 (10 at default)
// PORTS
// - clk        in   1  clock, all logic on rising edge
// - reset      in   1  synchronous, active-high
// - in_valid   in   1  X/Y carry a point this cycle
// - X          in   W  point x coordinate
// - Y          in   W  point y coordinate
// - busy       out  1  frame loaded, sorting or emitting; inputs ignored
// - out_valid  out  1  out_x/out_y/out_idx valid this cycle
// - out_x      out  W  emitted x
// - out_y      out  W  emitted y
// - out_idx    out  3  0 = object, 1..N_AP = AP0 then sorted APs
// - out_last   out  1  high with the final point of the frame
// BEHAVIOUR
// - Reset: state LOAD, load count 0, busy=0, out_valid=0, out_last=0, out_x/out_y/out_idx=0.
// - Reset mid-operation: same result on the next edge, partial frame discarded, no out_valid.
// - LOAD: each in_valid=1 cycle stores (X,Y) in slot cnt, cnt++.
//   - Slot 0 = object, slots 1..N_AP = AP0..AP(N_AP-1).
//   - The cycle storing slot N_AP moves to SORT; busy=1 from the next cycle.
// - SORT: exactly C cycles, one compare per cycle.
//   - Pass p = 0..N_AP-3; compare AP positions j,j+1 for j = 1..N_AP-2-p.
//   - vi = APi - AP0, 11-bit signed per component.
//   - cr = vj.x*vj1.y - vj.y*vj1.x: 22-bit products, 23-bit signed result, no truncation.
//   - cr < 0: swap the two slots. cr >= 0 (including collinear): keep order, so the sort is stable.
//   - AP0 and the object are never moved.
//   - Sort cycle count is fixed; it does not depend on data or on early completion.
// - EMIT: N_AP+1 consecutive cycles with out_valid=1 and out_idx 0..N_AP. No backpressure.
//   - out_last=1 only when out_idx=N_AP.
//   - Next cycle: out_valid=0, busy=0, state LOAD, cnt=0.
// - Latency: last AP sampled at edge t. SORT spans edges t+1..t+C. First out_valid is visible after edge t+C+1.
//   - out_last is visible after edge t+C+N_AP+1.
// - in_valid while busy=1 is ignored: no slot write, no counter change.
// - in_valid may drop between points in LOAD; gaps are allowed and the count holds.
// - All outputs are registered. out_x/out_y/out_idx hold their last values when out_valid=0.
//   - The bench checks these only when out_valid=1.
// TESTING
// - Sorted input: object (150,150), AP0 (100,100), AP1..5 = (200,100),(250,200),(200,250),(100,250),(50,200).
//   - Output idx 0..6 repeats the input order. First out_valid 11 edges after the AP5 sample. out_last on idx 6.
// - Reversed input: AP1..5 = (50,200),(100,250),(200,250),(250,200),(200,100), same AP0 and object.
//   - Emitted APs = (200,100),(250,200),(200,250),(100,250),(50,200).
// - Collinear case: AP1=(300,100), AP2=(200,100) on the same ray from AP0 (100,100), cr=0.
//   - The two keep input order; the other APs still sort correctly.
// - Reset high for 1 cycle during SORT, then the sorted-input frame is reapplied.
//   - No output from the aborted frame; the new frame emits correctly.
// - in_valid held 1 with junk (1023,1023) during SORT/EMIT, then a second frame.
//   - Junk never appears. The second frame loads correctly. 50 back-to-back random frames match the reference model.
// - Extreme coordinates: AP0 (0,0), APs at (1023,0),(1023,1023),(0,1023),(1,1023),(1023,1).
//   - Correct angular order; no overflow in cr.

Source files
------------

// File: rtl/geofence_ap_sorter.sv
// Geofence capture stage: buffers object + N_AP antenna points, sorts
// AP1..AP(N_AP-1) by angle around AP0, then replays the frame in order.
module geofence_ap_sorter #(
    parameter int W    = 10,
    parameter int N_AP = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         busy,
    output logic         out_valid,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic [2:0]   out_idx,
    output logic         out_last
);
    localparam int NS = N_AP + 1;
    localparam int CW = $clog2(NS + 1);
    localparam int PW = 2 * W + 2;
    localparam logic [CW-1:0] LAST_SLOT = CW'(N_AP);
    localparam logic [CW-1:0] EMIT_END  = CW'(NS);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] J_TOP     = CW'(N_AP - 2);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state, state_n;

    logic [W-1:0]  px [NS];
    logic [W-1:0]  py [NS];
    logic [CW-1:0] cnt, j, jmax, e, ja, jb;
    logic          load_en, sort_en, emit_en, sort_done, swap;

    logic signed [W:0]    vax, vay, vbx, vby;
    logic signed [PW-1:0] pab, pba;
    logic signed [PW:0]   cr;

    // Slot 0 is the object and slot 1 is AP0, so AP position j lives in slot j+1
    assign ja = j + ONE;
    assign jb = j + CW'(2);

    assign vax = $signed({1'b0, px[ja]}) - $signed({1'b0, px[1]});
    assign vay = $signed({1'b0, py[ja]}) - $signed({1'b0, py[1]});
    assign vbx = $signed({1'b0, px[jb]}) - $signed({1'b0, px[1]});
    assign vby = $signed({1'b0, py[jb]}) - $signed({1'b0, py[1]});

    assign pab = PW'(vax) * PW'(vby);
    assign pba = PW'(vay) * PW'(vbx);
    assign cr  = (PW + 1)'(pab) - (PW + 1)'(pba);

    // Strictly negative only: collinear points keep their input order
    assign swap = cr[PW];

    assign sort_done = (jmax == ONE) && (j == ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            LOAD: if (in_valid && cnt == LAST_SLOT) state_n = SORT;
            SORT: if (sort_done) state_n = EMIT;
            EMIT: if (e == EMIT_END) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        sort_en = 1'b0;
        emit_en = 1'b0;
        unique case (state)
            LOAD: load_en = in_valid;
            SORT: sort_en = 1'b1;
            EMIT: emit_en = (e != EMIT_END);
            default: load_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            j         <= ONE;
            jmax      <= J_TOP;
            e         <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_idx   <= '0;
        end else begin
            busy      <= (state_n != LOAD);
            out_valid <= emit_en;
            out_last  <= emit_en && (e == LAST_SLOT);
            if (load_en) begin
                px[cnt] <= X;
                py[cnt] <= Y;
                if (cnt == LAST_SLOT) begin
                    cnt  <= '0;
                    j    <= ONE;
                    jmax <= J_TOP;
                    e    <= '0;
                end else begin
                    cnt <= cnt + ONE;
                end
            end
            if (sort_en) begin
                if (swap) begin
                    px[ja] <= px[jb];
                    py[ja] <= py[jb];
                    px[jb] <= px[ja];
                    py[jb] <= py[ja];
                end
                if (j == jmax) begin
                    j    <= ONE;
                    jmax <= jmax - ONE;
                end else begin
                    j <= j + ONE;
                end
            end
            if (emit_en) begin
                out_x   <= px[e];
                out_y   <= py[e];
                out_idx <= 3'(e);
                e       <= e + ONE;
            end
        end
    end

endmodule

// File: tb/tb_geofence_ap_sorter.sv
// Bench for geofence_ap_sorter: directed vector table plus random frames,
// all emitted points checked against a scoreboard queue.
module tb_geofence_ap_sorter;
    localparam int W    = 10;
    localparam int N_AP = 6;
    localparam int NS   = N_AP + 1;
    localparam int C    = (N_AP - 1) * (N_AP - 2) / 2;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic [2:0]   out_idx;
    logic         out_last;

    geofence_ap_sorter #(.W(W), .N_AP(N_AP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .busy      (busy),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x[NS];
        int y[NS];
    } frame_t;

    typedef struct {
        frame_t in;
        frame_t exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2:0]   idx;
        logic         last;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            cmp_cnt++;
            if (sbq.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_out: got idx=%0d (%0d,%0d), required no output",
                         out_idx, out_x, out_y);
            end else begin
                mon_e = sbq.pop_front();
                if (out_x !== mon_e.x || out_y !== mon_e.y ||
                    out_idx !== mon_e.idx || out_last !== mon_e.last) begin
                    err_cnt++;
                    $display("FAIL out_point: got idx=%0d (%0d,%0d) last=%0b, required idx=%0d (%0d,%0d) last=%0b",
                             out_idx, out_x, out_y, out_last,
                             mon_e.idx, mon_e.x, mon_e.y, mon_e.last);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int req);
        cmp_cnt++;
        if (got != req) begin
            err_cnt++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    function automatic frame_t ref_sort(input frame_t f);
        frame_t r;
        longint vax, vay, vbx, vby, cr;
        int a, b, t;
        r = f;
        for (int p = 0; p <= N_AP - 3; p++) begin
            for (int jj = 1; jj <= N_AP - 2 - p; jj++) begin
                a   = jj + 1;
                b   = jj + 2;
                vax = r.x[a] - r.x[1];
                vay = r.y[a] - r.y[1];
                vbx = r.x[b] - r.x[1];
                vby = r.y[b] - r.y[1];
                cr  = vax * vby - vay * vbx;
                if (cr < 0) begin
                    t = r.x[a]; r.x[a] = r.x[b]; r.x[b] = t;
                    t = r.y[a]; r.y[a] = r.y[b]; r.y[b] = t;
                end
            end
        end
        return r;
    endfunction

    task automatic push_exp(input frame_t f);
        exp_t e;
        for (int s = 0; s < NS; s++) begin
            e.x    = W'(f.x[s]);
            e.y    = W'(f.y[s]);
            e.idx  = 3'(s);
            e.last = (s == N_AP);
            sbq.push_back(e);
        end
    endtask

    task automatic send_frame(input frame_t f, input bit gaps);
        for (int s = 0; s < NS; s++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                X = '1;
                Y = '1;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            X = W'(f.x[s]);
            Y = W'(f.y[s]);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input string nm);
        int k;
        for (k = 0; k < 100; k++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        if (k == 100) chk({nm, "_busy_timeout"}, 1, 0);
    endtask

    task automatic wait_drain(input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            if (sbq.size() == 0 && !busy && !out_valid) break;
            @(negedge clk);
        end
        if (k == 200) chk({nm, "_drain_timeout"}, sbq.size(), 0);
    endtask

    vec_t   vecs[4];
    frame_t fr;
    int     k;

    initial begin
        vecs[0].in.x  = '{150, 100, 200, 250, 200, 100, 50};
        vecs[0].in.y  = '{150, 100, 100, 200, 250, 250, 200};
        vecs[0].exp   = vecs[0].in;
        vecs[1].in.x  = '{150, 100, 50, 100, 200, 250, 200};
        vecs[1].in.y  = '{150, 100, 200, 250, 250, 200, 100};
        vecs[1].exp.x = '{150, 100, 200, 250, 200, 100, 50};
        vecs[1].exp.y = '{150, 100, 100, 200, 250, 250, 200};
        vecs[2].in.x  = '{150, 100, 300, 200, 100, 250, 50};
        vecs[2].in.y  = '{150, 100, 100, 100, 250, 200, 200};
        vecs[2].exp.x = '{150, 100, 300, 200, 250, 100, 50};
        vecs[2].exp.y = '{150, 100, 100, 100, 200, 250, 200};
        vecs[3].in.x  = '{512, 0, 1023, 1023, 0, 1, 1023};
        vecs[3].in.y  = '{512, 0, 0, 1023, 1023, 1023, 1};
        vecs[3].exp.x = '{512, 0, 1023, 1023, 1023, 1, 0};
        vecs[3].exp.y = '{512, 0, 0, 1, 1023, 1023, 1023};

        reset    = 1'b1;
        in_valid = 1'b0;
        X        = '0;
        Y        = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_out_xyidx", {out_x, out_y, out_idx}, 0);

        for (int i = 0; i < 4; i++) begin
            push_exp(vecs[i].exp);
            send_frame(vecs[i].in, i == 2);
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                if (k == 0) chk("busy_after_last_ap", busy, 1);
                if (out_valid) break;
            end
            chk("first_out_latency", k, C + 1);
            repeat (NS) @(negedge clk);
            chk("post_frame_out_valid", out_valid, 0);
            chk("post_frame_busy", busy, 0);
            wait_drain("vec");
        end

        // Abort a frame mid-sort; nothing from it may appear
        send_frame(vecs[1].in, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_sort", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        repeat (20) @(posedge clk);
        #1;
        push_exp(vecs[0].exp);
        send_frame(vecs[0].in, 1'b0);
        wait_drain("after_abort");

        // Junk held on the input while busy, then a second frame
        push_exp(vecs[3].exp);
        send_frame(vecs[3].in, 1'b0);
        in_valid = 1'b1;
        X = '1;
        Y = '1;
        wait_not_busy("junk");
        push_exp(vecs[1].exp);
        send_frame(vecs[1].in, 1'b0);
        wait_drain("junk");

        for (int f = 0; f < 50; f++) begin
            for (int s = 0; s < NS; s++) begin
                fr.x[s] = $urandom_range(0, 1000);
                fr.y[s] = $urandom_range(0, 1000);
            end
            push_exp(ref_sort(fr));
            send_frame(fr, 1'b0);
            wait_not_busy("rand");
        end
        wait_drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
